// File: rtl/axi_bresp_router.sv
// B-channel return path: an in-order FIFO of AW slave selects steers each slave's
// BVALID/BRESP to the master and the master's BREADY back to the head slave.
module axi_bresp_router #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned SEL_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             aw_hs_i,
   input  logic [SEL_W-1:0] aw_sel_i,
   input  logic             s0_BVALID,
   input  logic [1:0]       s0_BRESP,
   output logic             s0_BREADY,
   input  logic             s1_BVALID,
   input  logic [1:0]       s1_BRESP,
   output logic             s1_BREADY,
   input  logic             s2_BVALID,
   input  logic [1:0]       s2_BRESP,
   output logic             s2_BREADY,
   input  logic             s3_BVALID,
   input  logic [1:0]       s3_BRESP,
   output logic             s3_BREADY,
   output logic             bvalid,
   output logic [1:0]       bresp,
   input  logic             bready,
   output logic             full_o,
   output logic             empty_o,
   output logic             overflow_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [SEL_W-1:0] r_fifo [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic [SEL_W-1:0] w_head;
   logic [1:0]       w_idx;
   logic             w_head_mapped;
   logic [3:0]       w_s_bvalid;
   logic [1:0]       w_s_bresp [4];
   logic [3:0]       w_s_bready;
   logic             w_push;
   logic             w_pop;

   assign w_s_bvalid   = {s3_BVALID, s2_BVALID, s1_BVALID, s0_BVALID};
   assign w_s_bresp[0] = s0_BRESP;
   assign w_s_bresp[1] = s1_BRESP;
   assign w_s_bresp[2] = s2_BRESP;
   assign w_s_bresp[3] = s3_BRESP;

   assign w_head        = r_fifo[r_rd_ptr];
   assign w_idx         = w_head[1:0];
   assign w_head_mapped = (w_head <= SEL_W'(3));

   assign full_o     = (r_count == CNT_W'(DEPTH));
   assign empty_o    = (r_count == '0);
   assign overflow_o = r_overflow;

   // Unmapped heads answer DECERR locally and never raise a slave BREADY.
   always_comb begin
      bvalid     = 1'b0;
      bresp      = 2'b00;
      w_s_bready = '0;
      if (!empty_o) begin
         if (w_head_mapped) begin
            bvalid            = w_s_bvalid[w_idx];
            bresp             = w_s_bresp[w_idx];
            w_s_bready[w_idx] = bready;
         end else begin
            bvalid = 1'b1;
            bresp  = 2'b11;
         end
      end
   end

   assign s0_BREADY = w_s_bready[0];
   assign s1_BREADY = w_s_bready[1];
   assign s2_BREADY = w_s_bready[2];
   assign s3_BREADY = w_s_bready[3];

   assign w_pop  = bvalid && bready;
   assign w_push = aw_hs_i && (!full_o || w_pop);

   always_ff @(posedge clk_i) begin
      if (w_push && !rst_i) begin
         r_fifo[r_wr_ptr] <= aw_sel_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (aw_hs_i && full_o && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_bresp_router.sv
// Scoreboard bench for axi_bresp_router: a queue of outstanding selects predicts the
// routed response, slave readies and FIFO flags; a negedge monitor compares every cycle.
module tb_axi_bresp_router;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned SEL_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             aw_hs;
   logic [SEL_W-1:0] aw_sel;
   logic [3:0]       s_bv;
   logic [1:0]       s_br [4];
   logic [3:0]       s_rdy;
   logic             bvalid;
   logic [1:0]       bresp;
   logic             bready;
   logic             full, empty, ovf;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference state: outstanding selects in issue order, plus the sticky overflow flag.
   int unsigned q [$];
   bit          m_ovf;

   always #5 clk = ~clk;

   axi_bresp_router #(.DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
      .clk_i(clk), .rst_i(rst), .aw_hs_i(aw_hs), .aw_sel_i(aw_sel),
      .s0_BVALID(s_bv[0]), .s0_BRESP(s_br[0]), .s0_BREADY(s_rdy[0]),
      .s1_BVALID(s_bv[1]), .s1_BRESP(s_br[1]), .s1_BREADY(s_rdy[1]),
      .s2_BVALID(s_bv[2]), .s2_BRESP(s_br[2]), .s2_BREADY(s_rdy[2]),
      .s3_BVALID(s_bv[3]), .s3_BRESP(s_br[3]), .s3_BREADY(s_rdy[3]),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .full_o(full), .empty_o(empty), .overflow_o(ovf)
   );

   function automatic void model_out(output logic v, output logic [1:0] r, output logic [3:0] rdy);
      int unsigned h;
      v = 1'b0; r = 2'b00; rdy = 4'b0000;
      if (q.size() != 0) begin
         h = q[0];
         if (h <= 3) begin
            v = s_bv[h];
            r = s_br[h];
            rdy[h] = bready;
         end else begin
            v = 1'b1;
            r = 2'b11;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference update at each clock edge (inputs are stable here; they change #1 later).
   always @(posedge clk) begin
      logic v; logic [1:0] r; logic [3:0] rdy;
      bit pop;
      model_out(v, r, rdy);
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         pop = v && bready;
         if (aw_hs && q.size() == DEPTH && !pop) m_ovf = 1'b1;
         if (pop) void'(q.pop_front());
         if (aw_hs && (q.size() < DEPTH)) q.push_back(int'(aw_sel));
      end
   end

   // Monitor: compares on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic v; logic [1:0] r; logic [3:0] rdy;
      model_out(v, r, rdy);
      chk("bvalid", {7'd0, bvalid}, {7'd0, v});
      chk("bresp",  {6'd0, bresp},  {6'd0, r});
      chk("bready_s", {4'd0, s_rdy}, {4'd0, rdy});
      chk("full",   {7'd0, full},  {7'd0, q.size() == DEPTH});
      chk("empty",  {7'd0, empty}, {7'd0, q.size() == 0});
      chk("overflow", {7'd0, ovf}, {7'd0, m_ovf});
   end

   task automatic cyc(input int unsigned n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      aw_hs = 1'b0; aw_sel = '0; bready = 1'b0; s_bv = 4'b0000;
      for (int i = 0; i < 4; i++) s_br[i] = 2'b00;
   endtask

   task automatic push(input logic [SEL_W-1:0] sel);
      aw_hs = 1'b1; aw_sel = sel;
      cyc();
      aw_hs = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc();

      // Single write to s2, zero-latency handshake.
      push(4'd2);
      s_bv[2] = 1'b1; s_br[2] = 2'b00; bready = 1'b1;
      #1 chk("s2_route_bvalid", {7'd0, bvalid}, 8'd1);
      chk("s2_route_bready", {7'd0, s_rdy[2]}, 8'd1);
      cyc();
      idle();
      chk("s2_drained_empty", {7'd0, empty}, 8'd1);

      // In-order: s0 responds early but must wait for s1.
      push(4'd1);
      push(4'd0);
      s_bv[0] = 1'b1; s_br[0] = 2'b01; bready = 1'b1;
      cyc(2);
      s_bv[1] = 1'b1; s_br[1] = 2'b10;
      cyc();
      s_bv[1] = 1'b0;
      cyc();
      idle();

      // Unmapped select returns local DECERR.
      push(4'd7);
      #1 chk("decerr_bresp", {6'd0, bresp}, 8'd3);
      bready = 1'b1;
      cyc();
      idle();

      // Fill, drop on full, then accept alongside a pop.
      for (int i = 0; i < 4; i++) push(4'd9);
      chk("fill_full", {7'd0, full}, 8'd1);
      push(4'd9);
      chk("drop_ovf", {7'd0, ovf}, 8'd1);
      bready = 1'b1;
      push(4'd9);
      chk("pushpop_full", {7'd0, full}, 8'd1);
      cyc(5);
      idle();

      // Held response under backpressure.
      push(4'd3);
      s_bv[3] = 1'b1; s_br[3] = 2'b10;
      cyc(3);
      bready = 1'b1;
      cyc();
      idle();

      // Reset with outstanding writes and a pending slave response.
      push(4'd1); push(4'd2); push(4'd3);
      s_bv[1] = 1'b1;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bready = 1'b1;
      cyc(2);
      idle();

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom_range(0, 299) == 0);
         aw_hs  = ($urandom_range(0, 9) < 4);
         aw_sel = ($urandom_range(0, 9) < 8) ? SEL_W'($urandom_range(0, 3))
                                             : SEL_W'($urandom_range(4, 15));
         bready = ($urandom_range(0, 9) < 6);
         for (int i = 0; i < 4; i++) begin
            s_bv[i] = $urandom_range(0, 1);
            s_br[i] = 2'($urandom_range(0, 3));
         end
         cyc();
      end
      idle();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
